// File: rtl/uart_th_host_if.sv
// Command/response, transmit and receive signals between the threshold host and its neighbours.
interface uart_th_host_if;
  logic        cmd_valid;
  logic [2:0]  cmd_mode;
  logic        cmd_dir;
  logic        cmd_ready;
  logic        idle_ready_tx;
  logic        start_tx;
  logic [7:0]  data_tx;
  logic        data_ready_rx;
  logic [7:0]  data_rx;
  logic        resp_valid;
  logic [15:0] resp_value;
  logic        resp_error;
  logic        busy;

  modport master (
    output cmd_valid, cmd_mode, cmd_dir, idle_ready_tx, data_ready_rx, data_rx,
    input  cmd_ready, start_tx, data_tx, resp_valid, resp_value, resp_error, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_dir, idle_ready_tx, data_ready_rx, data_rx,
    output cmd_ready, start_tx, data_tx, resp_valid, resp_value, resp_error, busy
  );
endinterface

// File: rtl/uart_th_host.sv
// Threshold-adjust sequencer: sends mode and direction characters over a byte UART,
// checks their echoes, then collects the reported threshold (16-bit for solar, 8-bit signed otherwise).
module uart_th_host #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input logic           clk,
  input logic           rst,
  uart_th_host_if.slave bus
);

  localparam int unsigned      CNT_W    = 24;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       CHAR_A   = 8'h41;
  localparam logic [7:0]       CHAR_W   = 8'h77;
  localparam logic [7:0]       CHAR_S   = 8'h73;
  localparam logic [2:0]       MODE_BAD = 3'd7;
  localparam logic [2:0]       MODE_SOLAR = 3'd0;

  typedef enum logic [2:0] {
    IDLE, SEND_MODE, WAIT_MODE_ECHO, SEND_DIR, WAIT_DIR_ECHO, WAIT_LSB, WAIT_MSB, DONE
  } state_t;

  state_t           state;
  logic [2:0]       mode;
  logic             dir;
  logic [7:0]       lsb;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [15:0]      value;

  logic             cmd_ready;
  logic             busy;
  logic             start_tx;
  logic [7:0]       data_tx;
  logic             resp_valid;
  logic             resp_error;
  logic [15:0]      resp_value;

  logic [7:0]       mode_char;
  logic [7:0]       dir_char;
  logic             timeout;

  assign mode_char = CHAR_A + {5'd0, mode};
  assign dir_char  = dir ? CHAR_W : CHAR_S;
  assign timeout   = (cnt == CNT_LAST);

  // cnt defaults to zero, so every state change clears it; wait states count up only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= '0;
      dir        <= 1'b0;
      lsb        <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      value      <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      start_tx   <= 1'b0;
      data_tx    <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_value <= '0;
    end else begin
      start_tx   <= 1'b0;
      data_tx    <= '0;
      resp_valid <= 1'b0;
      cnt        <= '0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            mode      <= bus.cmd_mode;
            dir       <= bus.cmd_dir;
            err       <= 1'b0;
            value     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (bus.cmd_mode == MODE_BAD) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              state <= SEND_MODE;
            end
          end
        end
        SEND_MODE: begin
          if (bus.idle_ready_tx) begin
            start_tx <= 1'b1;
            data_tx  <= mode_char;
            state    <= WAIT_MODE_ECHO;
          end
        end
        WAIT_MODE_ECHO: begin
          if (bus.data_ready_rx) begin
            if (bus.data_rx == mode_char) begin
              state <= SEND_DIR;
            end else begin
              err   <= 1'b1;
              state <= DONE;
            end
          end else if (timeout) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SEND_DIR: begin
          if (bus.idle_ready_tx) begin
            start_tx <= 1'b1;
            data_tx  <= dir_char;
            state    <= WAIT_DIR_ECHO;
          end
        end
        WAIT_DIR_ECHO: begin
          if (bus.data_ready_rx) begin
            if (bus.data_rx == dir_char) begin
              state <= WAIT_LSB;
            end else begin
              err   <= 1'b1;
              state <= DONE;
            end
          end else if (timeout) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LSB: begin
          if (bus.data_ready_rx) begin
            lsb <= bus.data_rx;
            if (mode == MODE_SOLAR) begin
              state <= WAIT_MSB;
            end else begin
              value <= {{8{bus.data_rx[7]}}, bus.data_rx};
              state <= DONE;
            end
          end else if (timeout) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_MSB: begin
          if (bus.data_ready_rx) begin
            value <= {bus.data_rx, lsb};
            state <= DONE;
          end else if (timeout) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          resp_valid <= 1'b1;
          resp_error <= err;
          resp_value <= err ? 16'h0000 : value;
          cmd_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.busy       = busy;
  assign bus.start_tx   = start_tx;
  assign bus.data_tx    = data_tx;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_error = resp_error;
  assign bus.resp_value = resp_value;

endmodule

// File: tb/tb_uart_th_host.sv
// Randomized bench for uart_th_host: plays the remote UART peer and predicts each
// transaction's bytes, response and response cycle from the protocol rules.
module tb_uart_th_host;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  logic [7:0]  tx_q[$];
  int          tx_at_q[$];
  logic [16:0] resp_q[$];
  int          resp_at_q[$];
  logic        prev_start = 1'b0;
  logic        prev_resp  = 1'b0;

  uart_th_host_if bus();

  uart_th_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Monitor: sample 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rst) begin
      if (bus.start_tx) begin
        check("start_tx_b2b", 32'(prev_start), 32'd0);
        check("busy_on_tx", 32'({bus.busy, bus.cmd_ready}), 32'b10);
        tx_q.push_back(bus.data_tx);
        tx_at_q.push_back(cyc);
      end else begin
        check("data_tx_zero", 32'(bus.data_tx), 32'd0);
      end
      if (bus.resp_valid) begin
        check("resp_valid_b2b", 32'(prev_resp), 32'd0);
        check("idle_on_resp", 32'({bus.busy, bus.cmd_ready}), 32'b01);
        resp_q.push_back({bus.resp_error, bus.resp_value});
        resp_at_q.push_back(cyc);
      end
    end
    prev_start = bus.start_tx;
    prev_resp  = bus.resp_valid;
  end

  initial begin
    bus.idle_ready_tx = 1'b1;
    forever begin
      @(negedge clk);
      bus.idle_ready_tx = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench still running at cycle %0d", cyc);
    $fatal(1, "bench timed out");
  end

  function automatic int pick_delay();
    return ($urandom_range(0, 3) == 0) ? int'(TO) - 1 : int'($urandom_range(0, 4));
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, output int at);
    bus.data_ready_rx = 1'b1;
    bus.data_rx       = b;
    at                = cyc;
    @(negedge clk);
    bus.data_ready_rx = 1'b0;
    bus.data_rx       = 8'($urandom);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp, output int at, output bit ok);
    int n = 0;
    while (tx_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(tx_q.size()), 32'd1);
    ok = (tx_q.size() != 0);
    at = 0;
    if (ok) begin
      check(tag, 32'(tx_q.pop_front()), 32'(exp));
      at = tx_at_q.pop_front();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, 32'({bus.cmd_ready, bus.busy, bus.start_tx, bus.resp_valid, bus.resp_error,
                    bus.data_tx, bus.resp_value}),
          32'({5'b10000, 8'h00, 16'h0000}));
  endtask

  // fault: 0 none, 1 bad mode echo, 2 bad dir echo, 3..6 silence in mode/dir/lsb/msb wait
  task automatic run_txn(input logic [2:0] mode, input logic dir, input int fault,
                         input logic [7:0] lsb, input logic [7:0] msb, input bit idle_junk);
    logic [7:0]  mchar, dchar;
    logic        exp_err;
    logic [15:0] exp_val;
    logic [16:0] r;
    int          cmd_at, tx_at, rx_at, exp_at, n;
    bit          ok;

    mchar   = 8'("A" + int'(mode));
    dchar   = dir ? "w" : "s";
    exp_err = (mode == 3'd7) || (fault != 0);
    if (exp_err)        exp_val = 16'h0000;
    else if (mode == 0) exp_val = 16'(int'(msb) * 256 + int'(lsb));
    else                exp_val = 16'(int'($signed(lsb)));

    if (idle_junk && $urandom_range(0, 1) == 1) send_rx(8'($urandom), rx_at);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_dir   = dir;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    cmd_at = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 3'($urandom);
    bus.cmd_dir   = 1'($urandom);
    // a stray byte here lands in SEND_MODE or DONE and must be dropped
    if ($urandom_range(0, 1) == 1) send_rx(8'($urandom), rx_at);
    exp_at = cmd_at + 2;

    if (mode != 3'd7) begin
      wait_tx("mode_byte", mchar, tx_at, ok);
      if (!ok) return;
      // TO silent wait cycles, one DONE cycle, then the response
      exp_at = tx_at + int'(TO) + 1;
      if (fault != 3) begin
        wait_until(tx_at + pick_delay());
        send_rx((fault == 1) ? (mchar ^ 8'($urandom_range(1, 255))) : mchar, rx_at);
        exp_at = rx_at + 2;
        if (fault != 1) begin
          wait_tx("dir_byte", dchar, tx_at, ok);
          if (!ok) return;
          exp_at = tx_at + int'(TO) + 1;
          if (fault != 4) begin
            wait_until(tx_at + pick_delay());
            send_rx((fault == 2) ? (dchar ^ 8'($urandom_range(1, 255))) : dchar, rx_at);
            exp_at = rx_at + 2;
            if (fault != 2) begin
              exp_at = rx_at + int'(TO) + 2;
              if (fault != 5) begin
                wait_until(rx_at + 1 + pick_delay());
                send_rx(lsb, rx_at);
                exp_at = rx_at + 2;
                if (mode == 3'd0) begin
                  exp_at = rx_at + int'(TO) + 2;
                  if (fault != 6) begin
                    wait_until(rx_at + 1 + pick_delay());
                    send_rx(msb, rx_at);
                    exp_at = rx_at + 2;
                  end
                end
              end
            end
          end
        end
      end
    end

    n = 0;
    while (resp_q.size() == 0 && n < 4 * int'(TO) + 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_seen", 32'(resp_q.size()), 32'd1);
    if (resp_q.size() != 0) begin
      r = resp_q.pop_front();
      check("resp_error", 32'(r[16]), 32'(exp_err));
      check("resp_value", 32'(r[15:0]), 32'(exp_val));
      check("resp_cycle", 32'(resp_at_q.pop_front()), 32'(exp_at));
    end
    check("extra_tx", 32'(tx_q.size()), 32'd0);
  endtask

  // Abort a solar transaction while it waits for the LSB, then recover
  task automatic run_reset_mid();
    int at;
    bit ok;
    check("rst_pre_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 3'd0;
    bus.cmd_dir   = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_tx("rst_mode_byte", "A", at, ok);
    if (!ok) return;
    wait_until(at + 1);
    send_rx("A", at);
    wait_tx("rst_dir_byte", "w", at, ok);
    if (!ok) return;
    wait_until(at + 1);
    send_rx("w", at);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_async");
    repeat (2) @(negedge clk);
    check_reset_vals("rst_held");
    check("rst_no_resp", 32'(resp_q.size()), 32'd0);
    rst = 1'b0;
    run_txn(3'd7, 1'b0, 0, 8'h00, 8'h00, 1'b0);
    run_txn(3'd0, 1'b1, 0, 8'h5A, 8'h3C, 1'b1);
  endtask

  initial begin
    int          fault;
    logic [2:0]  mode;
    rst               = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_mode      = 3'd0;
    bus.cmd_dir       = 1'b0;
    bus.data_ready_rx = 1'b0;
    bus.data_rx       = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    run_txn(3'd2, 1'b1, 0, 8'h11, 8'h00, 1'b1);
    run_txn(3'd0, 1'b0, 0, 8'hC4, 8'h09, 1'b1);
    run_txn(3'd4, 1'b0, 0, 8'hF4, 8'h00, 1'b1);
    run_txn(3'd1, 1'b1, 1, 8'h00, 8'h00, 1'b1);
    run_txn(3'd3, 1'b0, 3, 8'h00, 8'h00, 1'b1);
    run_txn(3'd7, 1'b1, 0, 8'h00, 8'h00, 1'b1);
    run_reset_mid();

    for (int i = 0; i < 60; i++) begin
      mode  = 3'($urandom_range(0, 7));
      fault = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 6));
      if (mode != 3'd0 && fault == 6) fault = 5;
      run_txn(mode, 1'($urandom), fault, 8'($urandom), 8'($urandom), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_th_host.md
UART_TH_HOST -- requirements
Module: uart_th_host

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 500000, max cycles spent in any receive-wait state before aborting (1 to 2^24-1).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port cmd_valid, input, 1, host requests one threshold adjust transaction.
REQ-006 Port cmd_mode, input, 3, target: 0..6 maps to ASCII "A".."G" (0 = solar, 16-bit); 7 is invalid.
REQ-007 Port cmd_dir, input, 1, 1 = increment (ASCII "w"), 0 = decrement (ASCII "s").
REQ-008 Port cmd_ready, output, 1, high only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-009 Port idle_ready_tx, input, 1, byte UART transmitter idle.
REQ-010 Port start_tx, output, 1, one-cycle pulse launching data_tx.
REQ-011 Port data_tx, output, 8, byte to transmit; valid while start_tx high.
REQ-012 Port data_ready_rx, input, 1, one-cycle pulse: data_rx holds a received byte.
REQ-013 Port data_rx, input, 8, received byte.
REQ-014 Port resp_valid, output, 1, one-cycle pulse ending every accepted command.
REQ-015 Port resp_value, output, 16, reported threshold; held until next resp_valid.
REQ-016 Port resp_error, output, 1, qualifies resp_valid; held with resp_value.
REQ-017 Port busy, output, 1, high in every state except IDLE.

Function
REQ-018 States SHALL be: IDLE, SEND_MODE, WAIT_MODE_ECHO, SEND_DIR, WAIT_DIR_ECHO, WAIT_LSB, WAIT_MSB, DONE.
REQ-019 IDLE: on accept, latch cmd_mode/cmd_dir; mode 7 -> DONE with error; else -> SEND_MODE.
REQ-020 SEND_MODE: wait for idle_ready_tx high; that cycle register start_tx=1, data_tx="A"+mode for exactly one cycle, -> WAIT_MODE_ECHO.
REQ-021 WAIT_MODE_ECHO: data_ready_rx with data_rx == mode char -> SEND_DIR; any other byte -> DONE with error.
REQ-022 SEND_DIR: as SEND_MODE with data_tx = "w" or "s", -> WAIT_DIR_ECHO.
REQ-023 WAIT_DIR_ECHO: matching echo -> WAIT_LSB; mismatch -> DONE with error.
REQ-024 WAIT_LSB: first received byte stored as LSB; mode 0 -> WAIT_MSB, else -> DONE with resp_value = sign-extended byte.
REQ-025 WAIT_MSB: received byte forms resp_value = {MSB, LSB} (unsigned), -> DONE.
REQ-026 Each wait state SHALL run a counter cleared on entry; reaching TIMEOUT_CYCLES without data_ready_rx -> DONE with error.
REQ-027 data_ready_rx and timeout in the same cycle: the byte wins.
REQ-028 DONE: resp_valid=1 for one cycle, -> IDLE; on error resp_value=0, resp_error=1, else resp_error=0.
REQ-029 start_tx SHALL never be high for two consecutive cycles and never outside SEND_MODE/SEND_DIR exits; data_tx=0 when start_tx low.
REQ-030 Bytes arriving in IDLE, SEND_MODE, SEND_DIR or DONE SHALL be discarded.
REQ-031 cmd_valid outside IDLE SHALL be ignored; command-to-resp_valid minimum latency is 2 cycles (invalid mode).

Reset
REQ-032 During rst: state IDLE, cmd_ready=1, busy=0, start_tx=0, data_tx=0, resp_valid=0, resp_error=0, resp_value=0, counter=0.
REQ-033 rst asserted mid-transaction SHALL abort immediately with no resp_valid; first accept possible on the first rising edge after rst falls.

Verification
REQ-034 mode=2, dir=1, tx idle; echo "C","w", then 8'h11 -> start_tx bytes 8'h43 then 8'h77; resp_value 16'h0011, resp_error 0.
REQ-035 mode=0, dir=0; echo "A","s", then 8'hC4, 8'h09 -> resp_value 16'h09C4 (2500), resp_error 0.
REQ-036 mode=4, dir=0; echo "E","s", then 8'hF4 -> resp_value 16'hFFF4 (-12 sign-extended).
REQ-037 mode=1; echo returns "X" -> resp_error 1, resp_value 0, no "w"/"s" byte transmitted.
REQ-038 TIMEOUT_CYCLES=16, mode=3; no echo -> resp_valid with resp_error 1 exactly 16 cycles after WAIT_MODE_ECHO entry; mode=7 -> error in 2 cycles with no start_tx.
REQ-039 rst pulsed while in WAIT_LSB -> all outputs at reset values, no resp_valid; a following full transaction completes normally.
